// File: rtl/cpu_pkg.sv
// Shared types for the commit (memory) stage: FSM states, exception codes, access size.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } commit_state_t;

    typedef logic [1:0] exc_code_t;

    localparam exc_code_t EXC_NONE        = 2'b00;
    localparam exc_code_t EXC_MISALIGN    = 2'b01;
    localparam exc_code_t EXC_BUS_TIMEOUT = 2'b10;

    // Access size as carried by in_mem_byte.
    typedef enum logic {
        MEM_WORD = 1'b0,
        MEM_BYTE = 1'b1
    } mem_size_t;

endpackage

// File: rtl/cpu_mem_align.sv
// Lane steering for data-memory accesses: byte enables, store replication, load byte extract.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//   size/byte_off  : access size and byte offset within the word
//   store_data     : register value to store; wdata is the lane-replicated version
//   load_word      : raw memory word; load_value is the word or zero-extended byte
module cpu_mem_align
    import cpu_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  mem_size_t                              size,
    input  logic [$clog2(REG_WIDTH/8)-1:0]         byte_off,
    input  logic [REG_WIDTH-1:0]                   store_data,
    input  logic [REG_WIDTH-1:0]                   load_word,
    output logic [REG_WIDTH/8-1:0]                 be,
    output logic [REG_WIDTH-1:0]                   wdata,
    output logic [REG_WIDTH-1:0]                   load_value
);

    localparam int BE_W = REG_WIDTH / 8;

    always_comb begin
        be         = '1;
        wdata      = store_data;
        load_value = load_word;
        if (size == MEM_BYTE) begin
            be           = '0;
            be[byte_off] = 1'b1;
            // Memory picks the lane via be, so every lane carries the byte.
            wdata        = {BE_W{store_data[7:0]}};
            // Little-endian: byte 0 lives in bits [7:0].
            load_value   = {{(REG_WIDTH-8){1'b0}}, load_word[8*byte_off +: 8]};
        end
    end

endmodule

// File: rtl/cpu_commit_mem.sv
// Commit/memory stage: issues data-memory loads/stores, raises exceptions, registers result to writeback.
// Latency: 1 cycle for ALU ops and 0-wait accesses; memory ops add one cycle per unacked request cycle.
// Backpressure: stall (comb) freezes upstream while an access waits for dmem_ack and for the bus-error cycle.
//   clock/reset          : rising-edge clock, synchronous active-low reset
//   in_*                 : registered execute bundle, held stable by upstream while stall=1
//   stall, fw_commit_value : to pipeline control and forward unit
//   dmem_*               : req/ack data-memory port (word-aligned address, byte enables)
//   wb_*, exc_*          : registered writeback result and one-cycle exception pulse
module cpu_commit_mem
    import cpu_pkg::*;
#(
    parameter int REG_WIDTH  = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [$clog2(NUM_REGS)-1:0]   in_rd,
    input  logic                          in_reg_write,
    input  logic                          in_mem_read,
    input  logic                          in_mem_write,
    input  logic                          in_mem_byte,
    input  logic [REG_WIDTH-1:0]          in_alu_result,
    input  logic [REG_WIDTH-1:0]          in_rb_data,
    output logic                          stall,
    output logic [REG_WIDTH-1:0]          fw_commit_value,
    output logic                          dmem_req,
    output logic                          dmem_we,
    output logic [ADDR_WIDTH-1:0]         dmem_addr,
    output logic [REG_WIDTH-1:0]          dmem_wdata,
    output logic [REG_WIDTH/8-1:0]        dmem_be,
    input  logic                          dmem_ack,
    input  logic [REG_WIDTH-1:0]          dmem_rdata,
    output logic                          wb_valid,
    output logic [$clog2(NUM_REGS)-1:0]   wb_rd,
    output logic                          wb_reg_write,
    output logic [REG_WIDTH-1:0]          wb_value,
    output logic                          exc_valid,
    output exc_code_t                     exc_code
);

    localparam int BE_W  = REG_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    commit_state_t          state;
    logic [CNT_W-1:0]       tmo_cnt;
    logic                   drop_q;

    logic                   op_valid;
    logic                   mem_op;
    logic                   misaligned;
    logic                   issue;
    logic                   req_int;
    logic [ADDR_WIDTH-1:0]  addr_full;
    logic [BE_W-1:0]        align_be;
    logic [REG_WIDTH-1:0]   align_wdata;
    logic [REG_WIDTH-1:0]   load_value;

    // After a bus error upstream is released for one cycle while still showing
    // the failed op; masking it here is what drops it instead of retrying.
    assign op_valid   = in_valid & ~drop_q;
    assign mem_op     = op_valid & (in_mem_read | in_mem_write);
    assign misaligned = mem_op & ~in_mem_byte & (in_alu_result[OFF_W-1:0] != '0);
    assign issue      = mem_op & ~misaligned;
    assign req_int    = ((state == IDLE) & issue) | (state == WAIT);

    // Gating with reset makes the request drop in the very first reset cycle.
    assign dmem_req   = reset & req_int;
    assign stall      = reset & ((req_int & ~dmem_ack) | (state == ERROR));

    assign addr_full  = ADDR_WIDTH'(in_alu_result);
    assign dmem_we    = dmem_req & in_mem_write;
    assign dmem_addr  = dmem_req ? {addr_full[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign dmem_be    = dmem_req ? align_be : '0;
    assign dmem_wdata = dmem_req ? align_wdata : '0;

    assign fw_commit_value = in_alu_result;

    cpu_mem_align #(
        .REG_WIDTH (REG_WIDTH)
    ) u_align (
        .size       (in_mem_byte ? MEM_BYTE : MEM_WORD),
        .byte_off   (in_alu_result[OFF_W-1:0]),
        .store_data (in_rb_data),
        .load_word  (dmem_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_value (load_value)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            drop_q       <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_value     <= '0;
            exc_valid    <= 1'b0;
            exc_code     <= EXC_NONE;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            exc_valid    <= 1'b0;
            exc_code     <= EXC_NONE;
            drop_q       <= 1'b0;

            case (state)
                IDLE: begin
                    if (issue && !dmem_ack) begin
                        state   <= WAIT;
                        tmo_cnt <= CNT_W'(1);
                    end
                end
                WAIT: begin
                    // Ack is tested first so a same-cycle ack beats the timeout.
                    if (dmem_ack) begin
                        state   <= IDLE;
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == CNT_W'(TIMEOUT)) begin
                        state   <= ERROR;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ERROR: begin
                    state     <= IDLE;
                    drop_q    <= 1'b1;
                    wb_valid  <= 1'b1;
                    wb_rd     <= in_rd;
                    exc_valid <= 1'b1;
                    exc_code  <= EXC_BUS_TIMEOUT;
                end
                default: state <= IDLE;
            endcase

            // stall is 1 throughout ERROR, so this never collides with the case above.
            if (op_valid && !stall) begin
                wb_valid <= 1'b1;
                wb_rd    <= in_rd;
                wb_value <= in_alu_result;
                if (misaligned) begin
                    exc_valid <= 1'b1;
                    exc_code  <= EXC_MISALIGN;
                end else if (mem_op) begin
                    wb_reg_write <= in_reg_write & ~in_mem_write;
                    if (!in_mem_write) begin
                        wb_value <= load_value;
                    end
                end else begin
                    wb_reg_write <= in_reg_write;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_commit_mem.sv
// Bench for cpu_commit_mem: driver acts as execute stage and data memory, monitor scores writeback.
// Latency: expected results queued at issue, popped when wb_valid is seen.
// Backpressure: driver holds the bundle while stall=1, as the real execute stage does.
module tb_cpu_commit_mem;
    import cpu_pkg::*;

    localparam int RW = 32;
    localparam int NR = 32;
    localparam int AW = 32;
    localparam int TO = 16;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic [4:0]    in_rd;
    logic          in_reg_write;
    logic          in_mem_read;
    logic          in_mem_write;
    logic          in_mem_byte;
    logic [RW-1:0] in_alu_result;
    logic [RW-1:0] in_rb_data;
    logic          stall;
    logic [RW-1:0] fw_commit_value;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [RW-1:0] dmem_wdata;
    logic [3:0]    dmem_be;
    logic          dmem_ack;
    logic [RW-1:0] dmem_rdata;
    logic          wb_valid;
    logic [4:0]    wb_rd;
    logic          wb_reg_write;
    logic [RW-1:0] wb_value;
    logic          exc_valid;
    exc_code_t     exc_code;

    cpu_commit_mem #(
        .REG_WIDTH(RW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_byte(in_mem_byte),
        .in_alu_result(in_alu_result), .in_rb_data(in_rb_data),
        .stall(stall), .fw_commit_value(fw_commit_value),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_value(wb_value),
        .exc_valid(exc_valid), .exc_code(exc_code)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] val;
        bit          chk_rd;
        bit          chk_val;
        logic        exc_v;
        logic [1:0]  exc_c;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: scores every writeback beat against the queue head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (reset && wb_valid) begin
                if (exp_q.size() == 0) begin
                    chk("wb_unexpected", {63'd0, wb_valid}, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_reg_write", {63'd0, wb_reg_write}, {63'd0, e.rw});
                    chk("exc_valid", {63'd0, exc_valid}, {63'd0, e.exc_v});
                    chk("exc_code", {62'd0, exc_code}, {62'd0, e.exc_c});
                    if (e.chk_rd)  chk("wb_rd", {59'd0, wb_rd}, {59'd0, e.rd});
                    if (e.chk_val) chk("wb_value", {32'd0, wb_value}, {32'd0, e.val});
                end
            end else if (reset) begin
                chk("exc_without_wb", {63'd0, exc_valid}, 64'd0);
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Presents one execute bundle, plays memory with 'delay' unacked request
    // cycles (delay > TO means never ack), and holds the bundle while stalled.
    task automatic run_op(input logic v, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic mw, input logic mb,
                          input logic [31:0] alu, input logic [31:0] rb,
                          input int delay, input logic [31:0] rdata);
        exp_t        e;
        bit          mem, mis, done, tmo;
        int          req_n, stall_n, cyc, exp_req, exp_stall;
        logic [31:0] exp_addr, exp_wdata, exp_ld;
        logic [3:0]  exp_be;
        logic [1:0]  off;

        off       = alu[1:0];
        mem       = v && (mr || mw);
        mis       = mem && !mb && (off != 2'b00);
        tmo       = mem && !mis && (delay > TO);
        exp_addr  = alu & 32'hFFFF_FFFC;
        exp_be    = mb ? (4'b0001 << off) : 4'b1111;
        exp_wdata = mb ? (rb & 32'hFF) * 32'h0101_0101 : rb;
        exp_ld    = mb ? ((rdata >> (8 * off)) & 32'hFF) : rdata;
        exp_req   = (!mem || mis) ? 0 : (tmo ? TO + 1 : delay + 1);
        exp_stall = (!mem || mis) ? 0 : (tmo ? TO + 2 : delay);

        e = '{rd: rd, rw: rw, val: alu, chk_rd: 1, chk_val: 1, exc_v: 0, exc_c: EXC_NONE};
        if (mis) begin
            e.rw = 0; e.chk_rd = 0; e.chk_val = 0; e.exc_v = 1; e.exc_c = EXC_MISALIGN;
        end else if (tmo) begin
            e.rw = 0; e.chk_rd = 0; e.chk_val = 0; e.exc_v = 1; e.exc_c = EXC_BUS_TIMEOUT;
        end else if (mem && mw) begin
            e.rw = 0; e.chk_val = 0;
        end else if (mem) begin
            e.val = exp_ld;
        end
        if (v) exp_q.push_back(e);

        @(negedge clock);
        in_valid = v; in_rd = rd; in_reg_write = rw; in_mem_read = mr;
        in_mem_write = mw; in_mem_byte = mb; in_alu_result = alu; in_rb_data = rb;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        req_n = 0; stall_n = 0; cyc = 0; done = 0;
        while (!done) begin
            #1;
            if (cyc == 0) chk("fw_commit_value", {32'd0, fw_commit_value}, {32'd0, alu});
            if (dmem_req) begin
                chk("dmem_addr", {32'd0, dmem_addr}, {32'd0, exp_addr});
                chk("dmem_we", {63'd0, dmem_we}, {63'd0, mw});
                chk("dmem_be", {60'd0, dmem_be}, {60'd0, exp_be});
                if (mw) chk("dmem_wdata", {32'd0, dmem_wdata}, {32'd0, exp_wdata});
                if (req_n == delay) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata;
                end
                req_n++;
            end
            #1;
            if (stall) stall_n++;
            else done = 1;
            cyc++;
            if (!done && cyc > 40) begin
                checks++; errors++;
                $display("FAIL op_cycle_budget actual=%0d required<=40", cyc);
                done = 1;
            end
            if (!done) begin
                @(negedge clock);
                dmem_ack = 1'b0; dmem_rdata = $urandom;
            end
        end
        chk("req_cycles", 64'(req_n), 64'(exp_req));
        chk("stall_cycles", 64'(stall_n), 64'(exp_stall));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd0);
        chk({tag, "_wb_rd"}, {59'd0, wb_rd}, 64'd0);
        chk({tag, "_wb_reg_write"}, {63'd0, wb_reg_write}, 64'd0);
        chk({tag, "_wb_value"}, {32'd0, wb_value}, 64'd0);
        chk({tag, "_exc_valid"}, {63'd0, exc_valid}, 64'd0);
        chk({tag, "_exc_code"}, {62'd0, exc_code}, 64'd0);
        chk({tag, "_dmem_req"}, {63'd0, dmem_req}, 64'd0);
        chk({tag, "_stall"}, {63'd0, stall}, 64'd0);
    endtask

    initial begin : stimulus
        logic        v, rw, mr, mw, mb;
        logic [4:0]  rd;
        logic [31:0] alu, rb;
        int          k, dly;

        reset = 1'b0; in_valid = 0; in_rd = 0; in_reg_write = 0; in_mem_read = 0;
        in_mem_write = 0; in_mem_byte = 0; in_alu_result = 0; in_rb_data = 0;
        dmem_ack = 0; dmem_rdata = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b1;

        // Directed cases.
        run_op(1, 5'd5, 1, 0, 0, 0, 32'h1234, 32'h0, 0, 32'h0);
        run_op(1, 5'd7, 1, 1, 0, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        run_op(1, 5'd9, 1, 0, 1, 1, 32'h103, 32'hAB, 3, 32'h0);
        run_op(1, 5'd3, 1, 1, 0, 1, 32'h102, 32'h0, 1, 32'h11223344);
        run_op(1, 5'd4, 1, 1, 0, 0, 32'h102, 32'h0, 0, 32'h0);
        run_op(1, 5'd6, 1, 1, 0, 0, 32'h200, 32'h0, TO, 32'hCAFE0001);
        run_op(1, 5'd8, 1, 1, 0, 0, 32'h204, 32'h0, 99, 32'h0);
        run_op(1, 5'd2, 1, 1, 1, 1, 32'h301, 32'h5A, 2, 32'h0);
        run_op(0, 5'd1, 1, 0, 0, 0, 32'h55, 32'h0, 0, 32'h0);

        // Randomized mix.
        for (int i = 0; i < 150; i++) begin
            v   = ($urandom_range(0, 9) != 0);
            rd  = 5'($urandom);
            rw  = 1'($urandom);
            alu = $urandom;
            rb  = $urandom;
            k   = $urandom_range(0, 9);
            mr  = (k >= 4 && k <= 7) || k == 9;
            mw  = (k == 8 || k == 9);
            mb  = 1'($urandom);
            if (!mb && $urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
            k = $urandom_range(0, 19);
            if (k < 12)       dly = k % 4;
            else if (k == 12) dly = TO - 1;
            else if (k == 13) dly = TO;
            else if (k == 14) dly = 99;
            else              dly = $urandom_range(0, 8);
            run_op(v, rd, rw, mr, mw, mb, alu, rb, dly, $urandom);
        end

        // Leave a non-zero result in wb_value so reset has something to clear.
        run_op(1, 5'd11, 1, 0, 0, 0, 32'hA5A5_0F0F, 32'h0, 0, 32'h0);

        // Reset in the middle of a WAIT: everything must be zero at the next edge.
        @(negedge clock);
        in_valid = 1; in_rd = 5'd12; in_reg_write = 1; in_mem_read = 1; in_mem_write = 0;
        in_mem_byte = 0; in_alu_result = 32'h400; dmem_ack = 0;
        repeat (5) @(negedge clock);
        chk("pre_reset_req", {63'd0, dmem_req}, 64'd1);
        chk("pre_reset_stall", {63'd0, stall}, 64'd1);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_all_zero("mid_wait_reset");
        chk("mid_wait_reset_dmem_be", {60'd0, dmem_be}, 64'd0);
        chk("mid_wait_reset_dmem_addr", {32'd0, dmem_addr}, 64'd0);
        @(negedge clock);
        in_valid = 0;
        reset = 1'b1;

        // Recovery after reset.
        run_op(1, 5'd13, 1, 0, 0, 0, 32'h0BAD_F00D, 32'h0, 0, 32'h0);
        run_op(1, 5'd14, 1, 1, 0, 0, 32'h408, 32'h0, 2, 32'h7766_5544);
        @(negedge clock);
        in_valid = 0;
        repeat (3) @(posedge clock);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
